// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the five-stage Y86-64 core.
// Drives stall/bubble controls for each stage register, issues the branch
// mispredict flush and ret drain, tracks a sticky exception/halt state and
// counts hazard events in saturating counters.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   d_icode, d_srcA, d_srcB        instruction in D and its source registers
//   e_icode, e_dstM                instruction in E and its memory destination
//   m_icode, m_cnd, m_stat         instruction in M, branch condition, status
//   w_stat                         status of the instruction in W
//   f_stall .. w_stall             combinational stage-register controls
//   halted                         registered core-stopped flag
//   mispred_cnt/loaduse_cnt/ret_cnt  saturating hazard event counters
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic [3:0]       m_icode,
    input  logic             m_cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       w_stat,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic             halted,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] S_AOK    = 4'h1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic mispred, loaduse, retp, m_exc, w_exc;
    logic inc_mispred, inc_loaduse, inc_ret;

    // Hazard detection terms
    assign mispred = (m_icode == I_JXX) && !m_cnd;
    assign loaduse = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                     (e_dstM != RNONE) &&
                     ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    assign retp    = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    assign m_exc   = (m_stat != S_AOK);
    assign w_exc   = (w_stat != S_AOK);

    // Next state and stage controls
    always_comb begin
        state_nxt   = state;
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        d_bubble    = 1'b0;
        e_bubble    = 1'b0;
        m_bubble    = 1'b0;
        w_stall     = 1'b0;
        inc_mispred = 1'b0;
        inc_loaduse = 1'b0;
        inc_ret     = 1'b0;

        unique case (state)
            ST_RUN, ST_DRAIN: begin
                // Mispredict wins: any loaduse/ret behind it is wrong-path
                if (mispred) begin
                    d_bubble    = 1'b1;
                    e_bubble    = 1'b1;
                    inc_mispred = 1'b1;
                end else if (loaduse) begin
                    f_stall     = 1'b1;
                    d_stall     = 1'b1;
                    e_bubble    = 1'b1;
                    inc_loaduse = 1'b1;
                end else if (retp) begin
                    f_stall     = 1'b1;
                    d_bubble    = 1'b1;
                    inc_ret     = 1'b1;
                end

                w_stall = w_exc;
                if (state == ST_RUN) begin
                    m_bubble = m_exc || w_exc;
                    if (w_exc)
                        state_nxt = ST_HALT;
                    else if (m_exc)
                        state_nxt = ST_DRAIN;
                end else begin
                    // Keep younger instructions from committing behind the fault
                    m_bubble = 1'b1;
                    if (w_exc)
                        state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                m_bubble = 1'b1;
                w_stall  = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase

        // Reset flushes the pipeline regardless of state
        if (!rst_n) begin
            f_stall  = 1'b0;
            d_stall  = 1'b0;
            w_stall  = 1'b0;
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end
    end

    // State, halted flag and saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            mispred_cnt <= '0;
            loaduse_cnt <= '0;
            ret_cnt     <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state == ST_HALT);
            if (inc_mispred && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            if (inc_loaduse && (loaduse_cnt != '1))
                loaduse_cnt <= loaduse_cnt + CNT_W'(1);
            if (inc_ret && (ret_cnt != '1))
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (CNT_W=4 so saturation is reachable).
// Inputs are driven on the falling edge; expectations from a behavioural model
// are queued at drive time and compared 3ns later by the monitor.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    d_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
    logic [3:0]    e_icode = 4'h1, e_dstM = 4'hF;
    logic [3:0]    m_icode = 4'h1;
    logic          m_cnd = 1'b1;
    logic [3:0]    m_stat = 4'h1, w_stat = 4'h1;
    logic          f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, halted;
    logic [CW-1:0] mispred_cnt, loaduse_cnt, ret_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .RNONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstM(e_dstM),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_stat(m_stat), .w_stat(w_stat),
        .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble),
        .e_bubble(e_bubble), .m_bubble(m_bubble), .w_stall(w_stall),
        .halted(halted),
        .mispred_cnt(mispred_cnt), .loaduse_cnt(loaduse_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        logic [5:0] ctl;   // {f_stall,d_stall,d_bubble,e_bubble,m_bubble,w_stall}
        int       mc, lc, rc;
        logic     h;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: 0=RUN 1=DRAIN 2=HALT
    int   md_state = 0;
    logic md_halted = 1'b0;
    int   md_mis = 0, md_lu = 0, md_ret = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    // Drive one cycle of inputs and queue the expected response
    task automatic step(input string tag, input logic r,
                        input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] ed,
                        input logic [3:0] mi, input logic mc,
                        input logic [3:0] ms, input logic [3:0] ws);
        exp_t e;
        logic fs, ds, db, eb, mb, wst, mis, lu, rp, mex, wex;
        int   ns;
        @(negedge clk);
        rst_n = r; d_icode = di; d_srcA = sa; d_srcB = sb;
        e_icode = ei; e_dstM = ed; m_icode = mi; m_cnd = mc;
        m_stat = ms; w_stat = ws;

        e.tag = tag; e.mc = md_mis; e.lc = md_lu; e.rc = md_ret; e.h = md_halted;
        {fs, ds, db, eb, mb, wst} = 6'b0;
        ns = md_state;
        if (!r) begin
            {db, eb, mb} = 3'b111;
            q.push_back(e);
            q[$].ctl = {fs, ds, db, eb, mb, wst};
            md_state = 0; md_halted = 1'b0; md_mis = 0; md_lu = 0; md_ret = 0;
            return;
        end
        mis = (mi == 4'h7) && !mc;
        lu  = (ei == 4'h5 || ei == 4'hB) && ed != 4'hF && (ed == sa || ed == sb);
        rp  = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
        mex = (ms != 4'h1);
        wex = (ws != 4'h1);
        if (md_state == 2) begin
            {fs, ds, mb, wst} = 4'b1111;
        end else begin
            if (mis) begin
                db = 1'b1; eb = 1'b1; md_mis = sat_inc(md_mis);
            end else if (lu) begin
                fs = 1'b1; ds = 1'b1; eb = 1'b1; md_lu = sat_inc(md_lu);
            end else if (rp) begin
                fs = 1'b1; db = 1'b1; md_ret = sat_inc(md_ret);
            end
            wst = wex;
            if (md_state == 0) begin
                mb = mex || wex;
                ns = wex ? 2 : (mex ? 1 : 0);
            end else begin
                mb = 1'b1;
                ns = wex ? 2 : 1;
            end
        end
        e.ctl = {fs, ds, db, eb, mb, wst};
        q.push_back(e);
        md_halted = (md_state == 2);
        md_state  = ns;
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
    endtask

    // Monitor: compare the queued expectation mid-cycle
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (q.size() > 0) begin
            e = q.pop_front();
            check({e.tag, ".ctl"}, 32'({f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall}), 32'(e.ctl));
            check({e.tag, ".mis"}, 32'(mispred_cnt), 32'(e.mc));
            check({e.tag, ".lu"},  32'(loaduse_cnt), 32'(e.lc));
            check({e.tag, ".ret"}, 32'(ret_cnt),     32'(e.rc));
            check({e.tag, ".hlt"}, 32'(halted),      32'(e.h));
        end
    end

    logic [3:0] icset [6] = '{4'h1, 4'h5, 4'h7, 4'h9, 4'hB, 4'h6};

    initial begin
        // Reset and idle
        step("rst0", 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        step("rst1", 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        nop("idle0");
        nop("idle1");
        // Load/use, then same with no destination
        step("lu",    1'b1, 4'h6, 4'h1, 4'h3, 4'h5, 4'h3, 4'h1, 1'b1, 4'h1, 4'h1);
        step("lu_rn", 1'b1, 4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        step("lu_pop",1'b1, 4'h6, 4'h2, 4'h0, 4'hB, 4'h2, 4'h1, 1'b1, 4'h1, 4'h1);
        nop("idle2");
        // Ret drains through D, E, M then reaches W
        step("ret_d", 1'b1, 4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        step("ret_e", 1'b1, 4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        step("ret_m", 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h9, 1'b1, 4'h1, 4'h1);
        nop("ret_w");
        // Mispredict overrides loaduse and ret
        step("mis",   1'b1, 4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 4'h7, 1'b0, 4'h1, 4'h1);
        step("jtaken",1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h7, 1'b1, 4'h1, 4'h1);
        // Random hazard mix, no exceptions
        for (int i = 0; i < 30; i++)
            step("rnd", 1'b1, icset[$urandom_range(0, 5)], 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), icset[$urandom_range(0, 5)],
                 4'($urandom_range(0, 15)), icset[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), 4'h1, 4'h1);
        // Saturation: 20 loaduse cycles
        for (int i = 0; i < 20; i++)
            step("sat", 1'b1, 4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 4'h1, 1'b1, 4'h1, 4'h1);
        // Exception: M fault -> DRAIN, W fault -> HALT
        step("m_exc", 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h3, 4'h1);
        step("drain", 1'b1, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        step("w_exc", 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h3);
        step("halt0", 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h7, 1'b0, 4'h1, 4'h3);
        step("halt1", 1'b1, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 4'h7, 1'b0, 4'h1, 4'h1);
        nop("halt2");
        // Reset from HALT
        step("rst_h", 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 4'h1, 4'h1);
        nop("post0");
        step("post_lu", 1'b1, 4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 4'h1, 1'b1, 4'h1, 4'h1);
        nop("post1");

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 5 && q.size() != 0; i++)
            @(negedge clk);
        #5;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
